// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   DEF_ISIZE / DEF_DSIZE : default PC/address width and instruction width
//   DEF_NOP_INST          : instruction driven on empty or squashed IF/ID slots
//   fetch_mode_e          : per-edge action chosen by the fetch stage
//   sel_mode()            : priority decode redirect > stall > run
package if_fetch_stage_pkg;

  localparam int DEF_ISIZE = 32;
  localparam int DEF_DSIZE = 32;
  localparam logic [DEF_DSIZE-1:0] DEF_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_STALL    = 2'd1,
    MODE_REDIRECT = 2'd2
  } fetch_mode_e;

  // Reset is handled separately, so only the non-reset actions are decoded.
  function automatic fetch_mode_e sel_mode(input logic redirect, input logic stall);
    fetch_mode_e m;
    if (redirect)   m = MODE_REDIRECT;
    else if (stall) m = MODE_STALL;
    else            m = MODE_RUN;
    return m;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for the fetch stage.
// Holds the instruction that was in flight from instruction memory when decode
// stalled, so it is not lost while the IF/ID register is frozen.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   capture            : store cap_inst/cap_pc and mark the entry valid
//   drain              : entry has been consumed; mark it empty
//   flush              : discard the entry (wrong path)
//   cap_inst, cap_pc   : data to store on capture
//   valid, inst, pc    : current entry
module fetch_skid_buf
  import if_fetch_stage_pkg::*;
#(
  parameter int ISIZE = DEF_ISIZE,
  parameter int DSIZE = DEF_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             drain,
  input  logic             flush,
  input  logic [DSIZE-1:0] cap_inst,
  input  logic [ISIZE-1:0] cap_pc,
  output logic             valid,
  output logic [DSIZE-1:0] inst,
  output logic [ISIZE-1:0] pc
);

  // Only the valid bit is reset; the payload is ignored while valid is low.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      inst <= cap_inst;
      pc   <= cap_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end of the 5-stage pipeline.
// Owns the program counter, issues one word address per cycle to an
// instruction memory with 1-cycle read latency, and fills the IF/ID register.
// Decode stalls are absorbed by a one-entry skid buffer; redirects squash all
// wrong-path fetches.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : decode cannot accept; IF/ID holds
//   redirect_valid  : taken branch/jump, fetch restarts at redirect_pc
//   redirect_pc     : redirect target (word address)
//   imem_addr       : instruction memory address (registered pc_q)
//   imem_rdata      : instruction memory data, valid 1 cycle after imem_addr
//   inst_IF_ID, pc_IF_ID, npc_IF_ID, valid_IF_ID : IF/ID register
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int               ISIZE    = DEF_ISIZE,
  parameter int               DSIZE    = DEF_DSIZE,
  parameter logic [ISIZE-1:0] RESET_PC = '0,
  parameter logic [DSIZE-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [ISIZE-1:0] redirect_pc,
  output logic [ISIZE-1:0] imem_addr,
  input  logic [DSIZE-1:0] imem_rdata,
  output logic [DSIZE-1:0] inst_IF_ID,
  output logic [ISIZE-1:0] pc_IF_ID,
  output logic [ISIZE-1:0] npc_IF_ID,
  output logic             valid_IF_ID
);

  logic [ISIZE-1:0] pc_q;
  logic             req_v_q;
  logic [ISIZE-1:0] req_pc_q;

  logic             skid_v_q;
  logic [DSIZE-1:0] skid_inst_q;
  logic [ISIZE-1:0] skid_pc_q;

  fetch_mode_e      mode;
  logic             skid_capture;
  logic             skid_drain;
  logic             skid_flush;

  logic [DSIZE-1:0] load_inst;
  logic [ISIZE-1:0] load_pc;
  logic             load_v;

  assign imem_addr = pc_q;

  always_comb begin
    mode = sel_mode(redirect_valid, stall);
  end

  // The word in flight is captured only if a request was issued last cycle.
  assign skid_capture = (mode == MODE_STALL) && req_v_q;
  assign skid_drain   = (mode == MODE_RUN) && skid_v_q;
  assign skid_flush   = (mode == MODE_REDIRECT);

  fetch_skid_buf #(
    .ISIZE (ISIZE),
    .DSIZE (DSIZE)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture  (skid_capture),
    .drain    (skid_drain),
    .flush    (skid_flush),
    .cap_inst (imem_rdata),
    .cap_pc   (req_pc_q),
    .valid    (skid_v_q),
    .inst     (skid_inst_q),
    .pc       (skid_pc_q)
  );

  // The skid entry is older than anything in flight, so it goes first.
  always_comb begin
    load_inst = NOP_INST;
    load_pc   = req_pc_q;
    load_v    = req_v_q;
    if (skid_v_q) begin
      load_inst = skid_inst_q;
      load_pc   = skid_pc_q;
      load_v    = 1'b1;
    end else if (req_v_q) begin
      load_inst = imem_rdata;
    end
  end

  // Fetch / IF-ID register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_v_q     <= 1'b0;
      valid_IF_ID <= 1'b0;
      inst_IF_ID  <= NOP_INST;
      pc_IF_ID    <= '0;
      npc_IF_ID   <= '0;
    end else begin
      case (mode)
        MODE_REDIRECT: begin
          // Dropping req_v_q discards the wrong-path word arriving next cycle.
          pc_q        <= redirect_pc;
          req_v_q     <= 1'b0;
          valid_IF_ID <= 1'b0;
          inst_IF_ID  <= NOP_INST;
        end
        MODE_STALL: begin
          // Nothing is issued while stalled, so at most one word needs the skid.
          req_v_q <= 1'b0;
        end
        default: begin
          inst_IF_ID  <= load_inst;
          pc_IF_ID    <= load_pc;
          npc_IF_ID   <= load_pc + ISIZE'(1);
          valid_IF_ID <= load_v;
          req_v_q     <= 1'b1;
          req_pc_q    <= pc_q;
          pc_q        <= pc_q + ISIZE'(1);
        end
      endcase
    end
  end

  a_skid_req_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(skid_v_q && req_v_q)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_IF_ID;
  logic [31:0] pc_IF_ID;
  logic [31:0] npc_IF_ID;
  logic        valid_IF_ID;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_IF_ID     (inst_IF_ID),
    .pc_IF_ID       (pc_IF_ID),
    .npc_IF_ID      (npc_IF_ID),
    .valid_IF_ID    (valid_IF_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word[k] = k + 100, one-cycle read latency.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'd100;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] enpc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] enpc,
                              input logic [31:0] eaddr);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.enpc = enpc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst            = v.rst;
    stall          = v.stall;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid", n_vec, {31'd0, valid_IF_ID}, {31'd0, e.ev});
    chk("inst", n_vec, inst_IF_ID, e.ev ? mem_word(e.epc) : NOP);
    chk("imem_addr", n_vec, imem_addr, e.eaddr);
    if (e.ev || e.rst) begin
      chk("pc", n_vec, pc_IF_ID, e.epc);
      chk("npc", n_vec, npc_IF_ID, e.enpc);
    end
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    //            rst  stl  red  rpc            ev   epc            enpc           addr
    tbl.push_back(mk(1, 0, 0, 0,             0, 0,             0,             0));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0,             0,             1));
    tbl.push_back(mk(0, 0, 0, 0,             1, 0,             1,             2));
    tbl.push_back(mk(0, 0, 0, 0,             1, 1,             2,             3));
    tbl.push_back(mk(0, 0, 0, 0,             1, 2,             3,             4));
    tbl.push_back(mk(0, 0, 0, 0,             1, 3,             4,             5));
    tbl.push_back(mk(0, 0, 0, 0,             1, 4,             5,             6));
    // 3-cycle stall holding pc=4, then 5,6 with no gap
    tbl.push_back(mk(0, 1, 0, 0,             1, 4,             5,             6));
    tbl.push_back(mk(0, 1, 0, 0,             1, 4,             5,             6));
    tbl.push_back(mk(0, 1, 0, 0,             1, 4,             5,             6));
    tbl.push_back(mk(0, 0, 0, 0,             1, 5,             6,             7));
    tbl.push_back(mk(0, 0, 0, 0,             1, 6,             7,             8));
    // redirect to 40 while holding pc=6; 7 and 8 never appear
    tbl.push_back(mk(0, 0, 1, 40,            0, 0,             0,             40));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0,             0,             41));
    tbl.push_back(mk(0, 0, 0, 0,             1, 40,            41,            42));
    tbl.push_back(mk(0, 0, 0, 0,             1, 41,            42,            43));
    // fill the skid, then redirect+stall together
    tbl.push_back(mk(0, 1, 0, 0,             1, 41,            42,            43));
    tbl.push_back(mk(0, 1, 1, 40,            0, 0,             0,             40));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0,             0,             41));
    tbl.push_back(mk(0, 0, 0, 0,             1, 40,            41,            42));
    tbl.push_back(mk(0, 0, 0, 0,             1, 41,            42,            43));
    // fill the skid, then reset mid-stream (stall still high)
    tbl.push_back(mk(0, 1, 0, 0,             1, 41,            42,            43));
    tbl.push_back(mk(1, 1, 0, 0,             0, 0,             0,             0));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0,             0,             1));
    tbl.push_back(mk(0, 0, 0, 0,             1, 0,             1,             2));
    tbl.push_back(mk(0, 0, 0, 0,             1, 1,             2,             3));
    // PC wrap at the top of the address space
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFE, 0, 0,             0,             32'hFFFF_FFFE));
    tbl.push_back(mk(0, 0, 0, 0,             0, 0,             0,             32'hFFFF_FFFF));
    tbl.push_back(mk(0, 0, 0, 0,             1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk(0, 0, 0, 0,             1, 32'hFFFF_FFFF, 0,             1));
    tbl.push_back(mk(0, 0, 0, 0,             1, 0,             1,             2));

    foreach (tbl[i]) apply(tbl[i]);

    // Long stall: IF/ID holds pc=0 for 5 cycles, then 1 and 2 follow back to back.
    for (int k = 0; k < 5; k++) apply(mk(0, 1, 0, 0, 1, 0, 1, 2));
    apply(mk(0, 0, 0, 0, 1, 1, 2, 3));
    apply(mk(0, 0, 0, 0, 1, 2, 3, 4));

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
